// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler
// Demand-driven phase sequencer for a four-approach intersection. It rests in MAIN green
// (M1+M2), latches side-road, main-turn and pedestrian demand, picks the next served phase
// round-robin, and passes every change through yellow and all-red clearance. An emergency
// preempt forces a return to MAIN.
//
// Optional build macro: PED_WALK_EN. Defined: req_ped is latched, routes to SIDE and drives
// walk. Undefined: req_ped is ignored, pend_ped stays 0 and walk is tied 0.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   req_s     side-road demand (latched)
//   req_mt    main-turn demand (latched)
//   req_ped   pedestrian button (latched, served in SIDE)
//   emerg     emergency preempt, level
//   light_M1, light_M2, light_MT, light_S
//             lamp groups, {R,Y,G} one-hot
//   walk      pedestrian walk lamp
//   phase     0 MAIN, 1 MT, 2 SIDE, 3 clearance
module traffic_phase_scheduler #(
   parameter int unsigned GREEN_MIN = 8,
   parameter int unsigned GREEN_MAX = 16,
   parameter int unsigned YELLOW_T  = 4,
   parameter int unsigned ALLRED_T  = 2,
   parameter int unsigned CNT_W     = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_s,
   input  logic       req_mt,
   input  logic       req_ped,
   input  logic       emerg,
   output logic [2:0] light_M1,
   output logic [2:0] light_M2,
   output logic [2:0] light_MT,
   output logic [2:0] light_S,
   output logic       walk,
   output logic [1:0] phase
);

   typedef enum logic [1:0] {StGreen, StYellow, StAllred} state_e;
   typedef enum logic [1:0] {PhMain = 2'd0, PhMt = 2'd1, PhSide = 2'd2} phase_e;

   localparam logic [2:0] LampRed    = 3'b100;
   localparam logic [2:0] LampYellow = 3'b010;
   localparam logic [2:0] LampGreen  = 3'b001;

   // Timers load duration-1 so that exit on zero gives exactly the duration.
   localparam logic [CNT_W-1:0] LdGreenMin = CNT_W'(GREEN_MIN - 1);
   localparam logic [CNT_W-1:0] LdGreenMax = CNT_W'(GREEN_MAX - 1);
   localparam logic [CNT_W-1:0] LdYellow   = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] LdAllred   = CNT_W'(ALLRED_T - 1);

   state_e           state_q, state_d;
   phase_e           cur_ph_q, cur_ph_d;
   phase_e           nxt_ph_q, nxt_ph_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic             pend_s_q, pend_s_d;
   logic             pend_mt_q, pend_mt_d;
   logic             pend_ped_q, pend_ped_d;
   logic             rr_q, rr_d;
   logic             walk_q, walk_d;
   logic [2:0]       light_m1_q, light_m1_d;
   logic [2:0]       light_m2_q, light_m2_d;
   logic [2:0]       light_mt_q, light_mt_d;
   logic [2:0]       light_s_q, light_s_d;
   logic [1:0]       phase_q, phase_d;

   logic             ped_req;
   logic             side_want;
   logic [2:0]       lamp_on;

`ifdef PED_WALK_EN
   assign ped_req = req_ped;
`else
   logic unused_req_ped;
   assign unused_req_ped = req_ped;
   assign ped_req        = 1'b0;
`endif

   assign side_want = pend_s_q | pend_ped_q;

   always_comb begin
      state_d    = state_q;
      cur_ph_d   = cur_ph_q;
      nxt_ph_d   = nxt_ph_q;
      rr_d       = rr_q;
      walk_d     = walk_q;
      timer_d    = (timer_q == '0) ? '0 : timer_q - CNT_W'(1);
      pend_s_d   = pend_s_q | req_s;
      pend_mt_d  = pend_mt_q | req_mt;
      pend_ped_d = pend_ped_q | ped_req;

      unique case (state_q)
         StGreen: begin
            if (cur_ph_q == PhMain) begin
               // Resting phase: leave only after the minimum, on demand, and not in preempt.
               if ((timer_q == '0) && !emerg && (pend_mt_q || side_want)) begin
                  state_d = StYellow;
                  timer_d = LdYellow;
                  // rr=0 gives MT priority; rr then points at the loser.
                  if (pend_mt_q && (!side_want || !rr_q)) begin
                     nxt_ph_d = PhMt;
                     rr_d     = 1'b1;
                  end else begin
                     nxt_ph_d = PhSide;
                     rr_d     = 1'b0;
                  end
               end
            end else if (emerg || (timer_q == '0)) begin
               state_d  = StYellow;
               timer_d  = LdYellow;
               nxt_ph_d = PhMain;
            end
         end
         StYellow: begin
            if (emerg) nxt_ph_d = PhMain;
            if (timer_q == '0) begin
               state_d = StAllred;
               timer_d = LdAllred;
            end
         end
         StAllred: begin
            if (emerg) nxt_ph_d = PhMain;
            if (timer_q == '0) begin
               state_d  = StGreen;
               cur_ph_d = emerg ? PhMain : nxt_ph_q;
               walk_d   = 1'b0;
               timer_d  = LdGreenMin;
               if (cur_ph_d == PhMt) begin
                  pend_mt_d = 1'b0;
               end else if (cur_ph_d == PhSide) begin
                  timer_d    = LdGreenMax;
                  pend_s_d   = 1'b0;
                  pend_ped_d = 1'b0;
                  walk_d     = pend_ped_q;
               end
            end
         end
         default: begin
            state_d = StAllred;
            timer_d = LdAllred;
         end
      endcase

      if (state_d != StGreen) walk_d = 1'b0;

      // Output decode from next state so lamps are registered with the state.
      lamp_on    = (state_d == StGreen) ? LampGreen : LampYellow;
      light_m1_d = LampRed;
      light_m2_d = LampRed;
      light_mt_d = LampRed;
      light_s_d  = LampRed;
      if (state_d != StAllred) begin
         if (cur_ph_d != PhSide) light_m1_d = lamp_on;
         if (cur_ph_d == PhMain) light_m2_d = lamp_on;
         if (cur_ph_d == PhMt)   light_mt_d = lamp_on;
         if (cur_ph_d == PhSide) light_s_d  = lamp_on;
      end
      phase_d = (state_d == StGreen) ? cur_ph_d : 2'd3;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StAllred;
         cur_ph_q   <= PhMain;
         nxt_ph_q   <= PhMain;
         timer_q    <= LdAllred;
         pend_s_q   <= 1'b0;
         pend_mt_q  <= 1'b0;
         pend_ped_q <= 1'b0;
         rr_q       <= 1'b0;
         walk_q     <= 1'b0;
         light_m1_q <= LampRed;
         light_m2_q <= LampRed;
         light_mt_q <= LampRed;
         light_s_q  <= LampRed;
         phase_q    <= 2'd3;
      end else begin
         state_q    <= state_d;
         cur_ph_q   <= cur_ph_d;
         nxt_ph_q   <= nxt_ph_d;
         timer_q    <= timer_d;
         pend_s_q   <= pend_s_d;
         pend_mt_q  <= pend_mt_d;
         pend_ped_q <= pend_ped_d;
         rr_q       <= rr_d;
         walk_q     <= walk_d;
         light_m1_q <= light_m1_d;
         light_m2_q <= light_m2_d;
         light_mt_q <= light_mt_d;
         light_s_q  <= light_s_d;
         phase_q    <= phase_d;
      end
   end

   assign light_M1 = light_m1_q;
   assign light_M2 = light_m2_q;
   assign light_MT = light_mt_q;
   assign light_S  = light_s_q;
   assign walk     = walk_q;
   assign phase    = phase_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Testbench for traffic_phase_scheduler: directed scenarios plus randomized demand and
// preempt, every cycle compared against a segment/elapsed-time model of the phase rules.
module tb_traffic_phase_scheduler;

   localparam int GMIN = 8;
   localparam int GMAX = 16;
   localparam int YT   = 4;
   localparam int AT   = 2;

   logic       clk;
   logic       rst;
   logic       req_s, req_mt, req_ped, emerg;
   logic [2:0] light_M1, light_M2, light_MT, light_S;
   logic       walk;
   logic [1:0] phase;

   int vectors;
   int miscompares;

   // Model: segment 0 green / 1 yellow / 2 all-red; phase 0 MAIN / 1 MT / 2 SIDE.
   int m_seg, m_cur, m_nxt, m_age;
   bit m_ps, m_pmt, m_pp, m_rr, m_walk;

   int cnt_m1g, cnt_m1y, cnt_mtg, cnt_sg, cnt_sy, cnt_ar, cnt_walk;

   traffic_phase_scheduler #(
      .GREEN_MIN(GMIN),
      .GREEN_MAX(GMAX),
      .YELLOW_T (YT),
      .ALLRED_T (AT),
      .CNT_W    (8)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req_s   (req_s),
      .req_mt  (req_mt),
      .req_ped (req_ped),
      .emerg   (emerg),
      .light_M1(light_M1),
      .light_M2(light_M2),
      .light_MT(light_MT),
      .light_S (light_S),
      .walk    (walk),
      .phase   (phase)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [14:0] dut_vec();
      return {light_M1, light_M2, light_MT, light_S, walk, phase};
   endfunction

   function automatic logic [14:0] exp_vec();
      logic [2:0] on, m1, m2, mt, s;
      logic [1:0] ph;
      on = (m_seg == 0) ? 3'b001 : 3'b010;
      m1 = 3'b100; m2 = 3'b100; mt = 3'b100; s = 3'b100;
      if (m_seg != 2) begin
         if (m_cur != 2) m1 = on;
         if (m_cur == 0) m2 = on;
         if (m_cur == 1) mt = on;
         if (m_cur == 2) s = on;
      end
      ph = (m_seg == 0) ? 2'(m_cur) : 2'd3;
      return {m1, m2, mt, s, m_walk, ph};
   endfunction

   task automatic model_reset();
      m_seg = 2; m_cur = 0; m_nxt = 0; m_age = 1;
      m_ps = 0; m_pmt = 0; m_pp = 0; m_rr = 0; m_walk = 0;
   endtask

   // Advance the model by one clock using the inputs present at the edge.
   task automatic model_update();
      bit ps, pmt, pp;
      int dur;
      ps  = m_ps | req_s;
      pmt = m_pmt | req_mt;
`ifdef PED_WALK_EN
      pp  = m_pp | req_ped;
`else
      pp  = 1'b0;
`endif
      case (m_seg)
         0: begin
            if (m_cur == 0) begin
               if (m_age >= GMIN && !emerg && (m_pmt || m_ps || m_pp)) begin
                  if (m_pmt && (!m_rr || !(m_ps || m_pp))) begin
                     m_nxt = 1; m_rr = 1;
                  end else begin
                     m_nxt = 2; m_rr = 0;
                  end
                  m_seg = 1; m_age = 1;
               end else m_age++;
            end else begin
               dur = (m_cur == 1) ? GMIN : GMAX;
               if (emerg || m_age == dur) begin
                  m_seg = 1; m_nxt = 0; m_age = 1;
               end else m_age++;
            end
         end
         1: begin
            if (emerg) m_nxt = 0;
            if (m_age == YT) begin
               m_seg = 2; m_age = 1;
            end else m_age++;
         end
         default: begin
            if (emerg) m_nxt = 0;
            if (m_age == AT) begin
               m_seg = 0; m_cur = m_nxt; m_age = 1; m_walk = 0;
               if (m_cur == 1) pmt = 0;
               if (m_cur == 2) begin
                  m_walk = m_pp;
                  ps = 0; pp = 0;
               end
            end else m_age++;
         end
      endcase
      m_ps = ps; m_pmt = pmt; m_pp = pp;
      if (m_seg != 0) m_walk = 0;
   endtask

   task automatic clr();
      cnt_m1g = 0; cnt_m1y = 0; cnt_mtg = 0; cnt_sg = 0; cnt_sy = 0; cnt_ar = 0; cnt_walk = 0;
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_update();
      #1;
      chk(tag, 32'(dut_vec()), 32'(exp_vec()));
      if (light_M1 == 3'b001) cnt_m1g++;
      if (light_M1 == 3'b010) cnt_m1y++;
      if (light_MT == 3'b001) cnt_mtg++;
      if (light_S == 3'b001) cnt_sg++;
      if (light_S == 3'b010) cnt_sy++;
      if ({light_M1, light_M2, light_MT, light_S} == 12'b100_100_100_100) cnt_ar++;
      if (walk) cnt_walk++;
   endtask

   // Pulls reset between clock edges, checks the asynchronous effect, releases off-edge.
   task automatic do_reset(input string tag);
      req_s = 0; req_mt = 0; req_ped = 0; emerg = 0;
      #3;
      rst = 1'b0;
      #1;
      model_reset();
      chk(tag, 32'(dut_vec()), 32'(15'b100_100_100_100_0_11));
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      rst = 1'b1; req_s = 0; req_mt = 0; req_ped = 0; emerg = 0;
      model_reset();
      clr();

      // Idle start: two all-red cycles then MAIN green held.
      do_reset("reset_state");
      step("idle_e1");
      chk("idle_allred_e1", 32'(light_M1), 32'(3'b100));
      step("idle_e2");
      chk("idle_green_e2", 32'({light_M1, light_M2}), 32'(6'b001_001));
      for (int i = 0; i < 100; i++) step("idle_hold");
      chk("idle_phase", 32'(phase), 32'(0));

      // Side-road pulse during MAIN green.
      do_reset("reset_side");
      clr();
      for (int i = 1; i <= 37; i++) begin
         req_s = (i == 4);
         step("side_seq");
      end
      chk("side_main_green", cnt_m1g, 8);
      chk("side_main_yellow", cnt_m1y, 4);
      chk("side_s_green", cnt_sg, GMAX);
      chk("side_s_yellow", cnt_sy, 4);
      chk("side_allred", cnt_ar, 5);
      chk("side_walk", cnt_walk, 0);
      step("side_back");
      chk("side_back_main", 32'(phase), 32'(0));

      // Simultaneous MT and side demand: MT first, then SIDE.
      do_reset("reset_both");
      clr();
      for (int i = 1; i <= 66; i++) begin
         req_s  = (i == 1);
         req_mt = (i == 1);
         step("both_seq");
         if (i == 20) chk("both_mt_first", 32'(phase), 32'(1));
      end
      chk("both_mt_green", cnt_mtg, GMIN);
      chk("both_s_green", cnt_sg, GMAX);
      chk("both_end_main", 32'(phase), 32'(0));

      // Pedestrian-only demand.
      do_reset("reset_ped");
      clr();
      for (int i = 1; i <= 40; i++) begin
         req_ped = (i == 1);
         step("ped_seq");
      end
`ifdef PED_WALK_EN
      chk("ped_s_green", cnt_sg, GMAX);
      chk("ped_walk", cnt_walk, GMAX);
`else
      chk("ped_s_green", cnt_sg, 0);
      chk("ped_walk", cnt_walk, 0);
`endif

      // Emergency at SIDE green cycle 5, MT demand latched during preempt.
      do_reset("reset_emerg");
      clr();
      for (int i = 1; i <= 40; i++) begin
         req_s  = (i == 1);
         req_mt = (i == 30);
         emerg  = (i >= 21);
         step("emerg_seq");
      end
      chk("emerg_s_green", cnt_sg, 5);
      chk("emerg_s_yellow", cnt_sy, 4);
      chk("emerg_hold_main", 32'(phase), 32'(0));
      emerg = 0;
      clr();
      for (int i = 0; i < 30; i++) step("emerg_after");
      chk("emerg_mt_served", cnt_mtg, GMIN);

      // Asynchronous reset during MT yellow.
      do_reset("reset_mt");
      for (int i = 1; i <= 25; i++) begin
         req_mt = (i == 1);
         step("mt_seq");
      end
      chk("mt_yellow", 32'(light_MT), 32'(3'b010));
      do_reset("reset_mid_mt");
      clr();
      for (int i = 0; i < 30; i++) step("post_reset");
      chk("post_reset_no_mt", cnt_mtg, 0);
      chk("post_reset_main", cnt_m1g, 29);

      // Randomized demand and preempt against the model.
      do_reset("reset_rand");
      for (int i = 0; i < 3000; i++) begin
         req_s   = ($urandom_range(0, 99) < 4);
         req_mt  = ($urandom_range(0, 99) < 4);
         req_ped = ($urandom_range(0, 99) < 4);
         if ($urandom_range(0, 99) < 2) emerg = ~emerg;
         step("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
